// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the result bus arbiter.
package cpu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned RD_W   = 3;
  localparam int unsigned NUM_FU = 4;

  typedef logic [1:0] fu_id_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } wb_state_t;

  // Index of the set bit in a one-hot (or zero) grant vector.
  function automatic fu_id_t onehot_to_idx(input logic [NUM_FU-1:0] oh);
    fu_id_t idx;
    idx = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      if (oh[k]) idx = fu_id_t'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way priority search starting at ptr and wrapping 3->0; one-hot grant.
module rr_arbiter4
  import cpu_pkg::*;
(
  input  logic [NUM_FU-1:0] req,
  input  fu_id_t            ptr,
  output logic [NUM_FU-1:0] gnt
);

  fu_id_t idx;
  logic   found;

  always_comb begin
    gnt   = '0;
    idx   = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      idx = ptr + fu_id_t'(k);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/result_bus_arbiter.sv
// Arbitrates four FU results onto one registered writeback bus.
// Define RR_FAIRNESS_EN for round-robin; otherwise fixed priority FU0 > FU3.
module result_bus_arbiter #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned RD_W   = cpu_pkg::RD_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [cpu_pkg::NUM_FU-1:0]        fu_valid,
  input  logic [cpu_pkg::NUM_FU*DATA_W-1:0] fu_data,
  input  logic [cpu_pkg::NUM_FU*RD_W-1:0]   fu_rd,
  output logic [cpu_pkg::NUM_FU-1:0]        fu_ready,
  output logic                             wb_valid,
  output logic [DATA_W-1:0]                wb_data,
  output logic [RD_W-1:0]                  wb_rd,
  output logic [1:0]                       wb_src,
  input  logic                             wb_ready
);

  import cpu_pkg::*;

  wb_state_t          state;
  wb_state_t          state_nxt;
  logic               slot_free;
  logic [NUM_FU-1:0]  req;
  logic [NUM_FU-1:0]  gnt;
  logic               handshake;
  fu_id_t             gnt_idx;
  fu_id_t             ptr;
  logic [DATA_W-1:0]  sel_data;
  logic [RD_W-1:0]    sel_rd;

  // Requests are masked while the slot is busy or reset is held.
  assign slot_free = (state == ST_EMPTY) || wb_ready;
  assign req       = fu_valid & {NUM_FU{slot_free && !rst}};
  assign fu_ready  = gnt;
  assign handshake = |gnt;
  assign gnt_idx   = onehot_to_idx(gnt);
  assign wb_valid  = (state == ST_FULL);

  rr_arbiter4 u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (gnt)
  );

`ifdef RR_FAIRNESS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (handshake) begin
      ptr <= gnt_idx + fu_id_t'(1);
    end
  end
`else
  assign ptr = '0;
`endif

  // Payload of the granted FU; non-granted lanes contribute nothing.
  always_comb begin
    sel_data = '0;
    sel_rd   = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      if (gnt[k]) begin
        sel_data = sel_data | fu_data[k*DATA_W +: DATA_W];
        sel_rd   = sel_rd   | fu_rd[k*RD_W +: RD_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (handshake) state_nxt = ST_FULL;
      ST_FULL:  if (wb_ready && !handshake) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_data <= '0;
      wb_rd   <= '0;
      wb_src  <= '0;
    end else if (handshake) begin
      wb_data <= sel_data;
      wb_rd   <= sel_rd;
      wb_src  <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Scoreboard bench for result_bus_arbiter; expectations follow RR_FAIRNESS_EN.
module tb_result_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  fu_valid;
  logic [63:0] fu_data;
  logic [11:0] fu_rd;
  logic [3:0]  fu_ready;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic [2:0]  wb_rd;
  logic [1:0]  wb_src;
  logic        wb_ready;

  logic [15:0] d [4];
  logic [2:0]  r [4];
  logic [20:0] exp_q [$];
  int          total;
  int          bad;

  assign fu_data = {d[3], d[2], d[1], d[0]};
  assign fu_rd   = {r[3], r[2], r[1], r[0]};

  result_bus_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .fu_valid (fu_valid),
    .fu_data  (fu_data),
    .fu_rd    (fu_rd),
    .fu_ready (fu_ready),
    .wb_valid (wb_valid),
    .wb_data  (wb_data),
    .wb_rd    (wb_rd),
    .wb_src   (wb_src),
    .wb_ready (wb_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected writeback record for a one-hot grant, taken from the stimulus tables.
  task automatic push(input logic [3:0] g);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 0; k < 4; k++) if (g[k]) idx = 2'(k);
    exp_q.push_back({d[idx], r[idx], idx});
  endtask

  // One cycle, entered and left at posedge+1.
  task automatic step(input logic [3:0] v, input logic rdy, input logic [3:0] exp_g,
                      input logic exp_wbv);
    fu_valid = v;
    wb_ready = rdy;
    #1;
    check("fu_ready", 32'(fu_ready), 32'(exp_g));
    check("wb_valid", 32'(wb_valid), 32'(exp_wbv));
    if (exp_g != 4'b0000) push(exp_g);
    @(posedge clk);
    #1;
  endtask

  task automatic check_wb_zero();
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_fu_ready", 32'(fu_ready), 32'd0);
    check("rst_wb_data",  32'(wb_data),  32'd0);
    check("rst_wb_rd",    32'(wb_rd),    32'd0);
    check("rst_wb_src",   32'(wb_src),   32'd0);
  endtask

  task automatic do_reset();
    fu_valid = 4'b1111;
    wb_ready = 1'b1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_wb_zero();
    fu_valid = 4'b0000;
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every writeback accepted by the register file must match the queue head.
  always @(negedge clk) begin
    if (!rst && wb_valid === 1'b1 && wb_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_unexpected: got %h/%0d/%0d expected none", wb_data, wb_rd, wb_src);
      end else begin
        check("wb_item", 32'({wb_data, wb_rd, wb_src}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    fu_valid = 4'b0000;
    wb_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d[k] = 16'h0000;
      r[k] = 3'd0;
    end
    #1;
    do_reset();

    // Single FU0 result.
    d[0] = 16'h1234; r[0] = 3'd5;
    step(4'b0001, 1'b1, 4'b0001, 1'b0);
    step(4'b0000, 1'b1, 4'b0000, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 1'b0);

    // All FUs requesting continuously.
    do_reset();
    d[0] = 16'h1000; r[0] = 3'd1;
    d[1] = 16'h2001; r[1] = 3'd2;
    d[2] = 16'h3002; r[2] = 3'd3;
    d[3] = 16'h4003; r[3] = 3'd4;
`ifdef RR_FAIRNESS_EN
    step(4'b1111, 1'b1, 4'b0001, 1'b0);
    step(4'b1111, 1'b1, 4'b0010, 1'b1);
    step(4'b1111, 1'b1, 4'b0100, 1'b1);
    step(4'b1111, 1'b1, 4'b1000, 1'b1);
    step(4'b1111, 1'b1, 4'b0001, 1'b1);
`else
    for (int i = 0; i < 5; i++) step(4'b1111, 1'b1, 4'b0001, (i != 0));
`endif
    step(4'b0000, 1'b1, 4'b0000, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 1'b0);

    // Backpressure: FULL and stalled, FU2 waits.
    d[0] = 16'hBEEF; r[0] = 3'd2;
    d[2] = 16'h5A5A; r[2] = 3'd7;
    step(4'b0001, 1'b1, 4'b0001, 1'b0);
    d[0] = 16'h0000; r[0] = 3'd0;
    for (int i = 0; i < 3; i++) begin
      step(4'b0100, 1'b0, 4'b0000, 1'b1);
      check("stall_data", 32'(wb_data), 32'h0000BEEF);
      check("stall_rd",   32'(wb_rd),   32'd2);
      check("stall_src",  32'(wb_src),  32'd0);
    end
    d[0] = 16'hBEEF; r[0] = 3'd2;
    step(4'b0100, 1'b1, 4'b0100, 1'b1);
    check("stall_src2", 32'(wb_src), 32'd2);
    step(4'b0000, 1'b1, 4'b0000, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 1'b0);

    // FU1 and FU3 both requesting, then FU1 drops.
    d[1] = 16'h0A11; r[1] = 3'd6;
    d[3] = 16'h0C33; r[3] = 3'd1;
`ifdef RR_FAIRNESS_EN
    step(4'b1010, 1'b1, 4'b1000, 1'b0);
    step(4'b1010, 1'b1, 4'b0010, 1'b1);
    step(4'b1010, 1'b1, 4'b1000, 1'b1);
    step(4'b1010, 1'b1, 4'b0010, 1'b1);
`else
    for (int i = 0; i < 4; i++) step(4'b1010, 1'b1, 4'b0010, (i != 0));
`endif
    step(4'b1000, 1'b1, 4'b1000, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 1'b0);

    // Mid-cycle reset while FULL discards the held result.
    d[0] = 16'h7777; r[0] = 3'd3;
    step(4'b0001, 1'b0, 4'b0001, 1'b0);
    check("pre_rst_valid", 32'(wb_valid), 32'd1);
    fu_valid = 4'b1001;
    wb_ready = 1'b1;
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    check_wb_zero();
    fu_valid = 4'b0000;
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    d[0] = 16'h0F0F; r[0] = 3'd4;
    d[3] = 16'hF0F0; r[3] = 3'd5;
    step(4'b1001, 1'b1, 4'b0001, 1'b0);
    step(4'b0000, 1'b1, 4'b0000, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 1'b0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_bus_arbiter.md
RESULT_BUS_ARBITER -- requirements
Module: result_bus_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, result data width.
REQ-002 SHALL have parameter RD_W, default 3, destination register address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port fu_valid  input  4  per-functional-unit result valid; bit i = FU i.
REQ-006 SHALL have port fu_data  input  4*DATA_W  FU i result in bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port fu_rd  input  4*RD_W  FU i destination in bits [i*RD_W +: RD_W].
REQ-008 SHALL have port fu_ready  output  4  one-hot (or zero) accept to FU i.
REQ-009 SHALL have port wb_valid  output  1  writeback bus holds a result.
REQ-010 SHALL have port wb_data  output  DATA_W  writeback result.
REQ-011 SHALL have port wb_rd  output  RD_W  writeback destination.
REQ-012 SHALL have port wb_src  output  2  index of the FU that produced the result.
REQ-013 SHALL have port wb_ready  input  1  register file accepts the writeback this cycle.

Function
REQ-014 SHALL hold one output register stage with two states: EMPTY (wb_valid=0), FULL (wb_valid=1).
REQ-015 SHALL define "slot free" = EMPTY, or FULL with wb_ready=1.
REQ-016 SHALL, when slot free and any fu_valid bit set, assert exactly one fu_ready bit (the grant) in the same cycle, combinationally.
REQ-017 SHALL keep fu_ready all-zero when the slot is not free or no fu_valid bit is set.
REQ-018 SHALL load wb_data, wb_rd, wb_src from the granted FU on the edge where fu_valid[i] and fu_ready[i] are both 1; latency one cycle from handshake to wb_valid.
REQ-019 SHALL transition: EMPTY + grant -> FULL; FULL + wb_ready + grant -> FULL with new data (no bubble); FULL + wb_ready + no grant -> EMPTY; FULL + !wb_ready -> FULL, outputs stable.
REQ-020 SHALL keep wb_data, wb_rd, wb_src unchanged while FULL and wb_ready=0.
REQ-021 SHALL, in round-robin mode, search from priority pointer ptr upward modulo 4 (ptr, ptr+1, ... wrap 3->0) and grant the first valid FU.
REQ-022 SHALL update ptr to (granted index + 1) mod 4 on every handshake; ptr unchanged when no handshake.
REQ-023 SHALL ignore fu_data/fu_rd of non-granted FUs; a non-granted FU holds its request until granted.

Reset
REQ-024 SHALL on rst=1 immediately force EMPTY, wb_valid=0, wb_data=0, wb_rd=0, wb_src=0, ptr=0, independent of clk.
REQ-025 SHALL drive fu_ready=0 while rst=1; a result held in the output stage at reset is discarded.
REQ-026 SHALL resume arbitration on the first rising edge after rst deasserts.

Configuration
REQ-027 SHALL, with RR_FAIRNESS_EN defined, use round-robin arbitration per REQ-021/022.
REQ-028 SHALL, without RR_FAIRNESS_EN, use fixed priority FU0 > FU1 > FU2 > FU3, ptr register omitted; all other behaviour identical.

Structure
REQ-029 SHALL take DATA_W, RD_W, NUM_FU=4 constants and fu_id_t (2-bit FU index typedef) from shared package cpu_pkg.
REQ-030 SHALL place grant logic in sub-module rr_arbiter4 (inputs req[3:0], ptr; output one-hot gnt[3:0]); output stage and ptr live in the top.

Verification
REQ-031 SHALL cover: reset, fu_valid=4'b0001, fu_data FU0=16'h1234, rd=5, wb_ready=1 -> fu_ready=4'b0001, next cycle wb_valid=1, wb_data=16'h1234, wb_rd=5, wb_src=0.
REQ-032 SHALL cover: RR_FAIRNESS_EN, fu_valid=4'b1111 held, wb_ready=1 -> grants in order FU0,FU1,FU2,FU3,FU0, one per cycle, no bubble on wb_valid.
REQ-033 SHALL cover: FULL with wb_ready=0 for 3 cycles, fu_valid=4'b0100 -> fu_ready=0 and wb outputs stable; wb_ready=1 -> FU2 granted same cycle, wb_src=2 next cycle.
REQ-034 SHALL cover: no RR_FAIRNESS_EN, fu_valid=4'b1010 -> FU1 granted every cycle while held; FU3 granted only after FU1 drops.
REQ-035 SHALL cover: rst asserted mid-cycle while FULL -> wb_valid=0 and fu_ready=0 before next clk edge; after release, ptr=0 so fu_valid=4'b1001 grants FU0.
